isr_unit: RTL and testbench

- In-Service Register block of an 8259-style programmable interrupt controller.
- Marks the acknowledged interrupt level as in-service on each acknowledge pulse and clears it by automatic EOI (AEOI), specific EOI or non-specific EOI.
- Provides the 8-bit data-bus value: the interrupt vector during acknowledge, or the ISR contents on a status read.
- Sits between the priority resolver, the control logic (acknowledge/EOI/cascade) and the data-bus buffer.

---
 rtl/pic_pkg.sv | 34 +++
 rtl/pulse_edge_detect.sv | 34 +++
 rtl/isr_unit.sv | 121 ++++++++++++
 tb/tb_isr_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the programmable interrupt controller blocks.
//   NUM_IR            : number of interrupt request levels (fixed at 8)
//   ir_level_t        : 3-bit interrupt level index
//   ir_vec_t          : 8-bit per-level bit vector
//   lowest_set_t      : result of a fixed-priority search (valid + index)
//   lowest_set_index(): find the highest-priority (lowest index) set bit
package pic_pkg;

  localparam int NUM_IR = 8;

  typedef logic [2:0] ir_level_t;
  typedef logic [NUM_IR-1:0] ir_vec_t;

  typedef struct packed {
    logic      valid;
    ir_level_t idx;
  } lowest_set_t;

  // IR0 has the highest priority, so the search walks downward and the
  // last hit (the lowest index) is the one that survives.
  function automatic lowest_set_t lowest_set_index(input ir_vec_t vec);
    lowest_set_t res;
    res.valid = 1'b0;
    res.idx   = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res.valid = 1'b1;
        res.idx   = ir_level_t'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pulse_edge_detect.sv
// Rise/fall detector for a control pulse that is synchronous to clk.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   pulse_in : pulse to monitor
//   rise     : 1 for the single cycle in which pulse_in is seen going high
//   fall     : 1 for the single cycle in which pulse_in is seen going low
module pulse_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic rise,
  output logic fall
);

  logic prev_reg;
  logic armed_reg;

  // armed_reg stays low for the first clock after reset so that a pulse
  // already high when reset releases is absorbed into prev_reg instead of
  // being reported as a fresh rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg  <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      prev_reg  <= pulse_in;
      armed_reg <= 1'b1;
    end
  end

  assign rise = armed_reg & pulse_in & ~prev_reg;
  assign fall = armed_reg & ~pulse_in & prev_reg;

endmodule

// File: rtl/isr_unit.sv
// In-Service Register of an 8259-style interrupt controller.
// Marks the granted level in service on each acknowledge pulse, clears
// levels by automatic, specific or non-specific EOI, and supplies the
// data-bus value (interrupt vector or ISR status).
//   clk, rst             : clock, asynchronous active-high reset
//   READ_IS, read        : status read select / active-low read strobe
//   S_P                  : acknowledge/set pulse
//   AEOI                 : automatic EOI mode
//   SPECIFIC_EOI         : specific EOI command pulse (clears L123)
//   NON_SPECIFIC_EOI     : non-specific EOI command pulse
//   V_A                  : vector base bits T7..T3
//   L123                 : level for specific EOI
//   highest_priority_int : level granted by the priority resolver
//   SNGL, selected_slave, IRR_slave : cascade controls
//   ISR_reg              : in-service register
//   ISR_R                : data-bus output value
module isr_unit
  import pic_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            READ_IS,
  input  logic            read,
  input  logic            S_P,
  input  logic            AEOI,
  input  logic            SPECIFIC_EOI,
  input  logic            NON_SPECIFIC_EOI,
  input  logic [4:0]      V_A,
  input  logic [2:0]      L123,
  input  logic [2:0]      highest_priority_int,
  input  logic            SNGL,
  input  logic            selected_slave,
  input  logic [7:0]      IRR_slave,
  output logic [7:0]      ISR_reg,
  output logic [7:0]      ISR_R
);

  // Pulse order in the edge-detector vectors.
  localparam int P_SP   = 0;
  localparam int P_SEOI = 1;
  localparam int P_NEOI = 2;

  logic [2:0]  pulse_vec;
  logic [2:0]  rise_vec;
  logic [2:0]  fall_vec;
  logic        unused_fall;

  ir_vec_t     vector_reg;
  ir_vec_t     vector_next;
  ir_level_t   aeoi_level_reg;
  ir_level_t   aeoi_level_next;
  ir_vec_t     isr_next;
  ir_vec_t     clr_mask;
  ir_vec_t     set_mask;
  lowest_set_t lowest;
  logic        slave_drives_bus;

  assign pulse_vec = {NON_SPECIFIC_EOI, SPECIFIC_EOI, S_P};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
      pulse_edge_detect u_edge (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_vec[gi]),
        .rise     (rise_vec[gi]),
        .fall     (fall_vec[gi])
      );
    end
  endgenerate

  // Only the acknowledge pulse has a meaningful falling edge.
  assign unused_fall = |fall_vec[P_NEOI:P_SEOI];

  // A cascaded level owned by another device: that slave drives the bus.
  assign slave_drives_bus = SNGL & IRR_slave[highest_priority_int] & ~selected_slave;

  always_comb begin
    clr_mask        = '0;
    set_mask        = '0;
    lowest          = lowest_set_index(ISR_reg);
    vector_next     = vector_reg;
    aeoi_level_next = aeoi_level_reg;

    if (rise_vec[P_SEOI]) begin
      clr_mask[L123] = 1'b1;
    end
    if (rise_vec[P_NEOI] && lowest.valid) begin
      clr_mask[lowest.idx] = 1'b1;
    end
    // AEOI clears the level captured at the acknowledge rise, even if the
    // resolver has moved on by the time the pulse falls.
    if (AEOI && fall_vec[P_SP]) begin
      clr_mask[aeoi_level_reg] = 1'b1;
    end

    if (rise_vec[P_SP]) begin
      set_mask[highest_priority_int] = 1'b1;
      aeoi_level_next                = highest_priority_int;
      vector_next = slave_drives_bus ? '0 : {V_A, highest_priority_int};
    end

    // Clears first, then the set: a set wins when both hit the same bit.
    isr_next = (ISR_reg & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ISR_reg        <= '0;
      vector_reg     <= '0;
      aeoi_level_reg <= '0;
    end else begin
      ISR_reg        <= isr_next;
      vector_reg     <= vector_next;
      aeoi_level_reg <= aeoi_level_next;
    end
  end

  assign ISR_R = (READ_IS && !read) ? ISR_reg : vector_reg;

endmodule

// File: tb/tb_isr_unit.sv
module tb_isr_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       READ_IS;
  logic       read;
  logic       S_P;
  logic       AEOI;
  logic       SPECIFIC_EOI;
  logic       NON_SPECIFIC_EOI;
  logic [4:0] V_A;
  logic [2:0] L123;
  logic [2:0] highest_priority_int;
  logic       SNGL;
  logic       selected_slave;
  logic [7:0] IRR_slave;
  logic [7:0] ISR_reg;
  logic [7:0] ISR_R;

  isr_unit dut (
    .clk                  (clk),
    .rst                  (rst),
    .READ_IS              (READ_IS),
    .read                 (read),
    .S_P                  (S_P),
    .AEOI                 (AEOI),
    .SPECIFIC_EOI         (SPECIFIC_EOI),
    .NON_SPECIFIC_EOI     (NON_SPECIFIC_EOI),
    .V_A                  (V_A),
    .L123                 (L123),
    .highest_priority_int (highest_priority_int),
    .SNGL                 (SNGL),
    .selected_slave       (selected_slave),
    .IRR_slave            (IRR_slave),
    .ISR_reg              (ISR_reg),
    .ISR_R                (ISR_R)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    bit         sel_r;   // 0: ISR_reg, 1: ISR_R
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  task automatic expect_isr(input string tag, input logic [7:0] e);
    exp_t x;
    x.tag = tag; x.sel_r = 1'b0; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic expect_bus(input string tag, input logic [7:0] e);
    exp_t x;
    x.tag = tag; x.sel_r = 1'b1; x.exp = e;
    sb.push_back(x);
  endtask

  // Pop every pending expectation and compare against the live outputs.
  task automatic check_sb();
    exp_t       x;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      x   = sb.pop_front();
      obs = x.sel_r ? ISR_R : ISR_reg;
      total++;
      assert (obs === x.exp) begin
        passed++;
        $display("check %-14s %s = %h ok", x.tag, x.sel_r ? "ISR_R  " : "ISR_reg", obs);
      end else begin
        $error("FAIL %s: %s observed %h expected %h", x.tag,
               x.sel_r ? "ISR_R" : "ISR_reg", obs, x.exp);
      end
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse(input logic [2:0] lvl);
    highest_priority_int = lvl;
    S_P = 1'b1; tick();
    S_P = 1'b0; tick();
  endtask

  task automatic seoi_pulse(input logic [2:0] lvl);
    L123 = lvl;
    SPECIFIC_EOI = 1'b1; tick();
    SPECIFIC_EOI = 1'b0; tick();
  endtask

  task automatic neoi_pulse();
    NON_SPECIFIC_EOI = 1'b1; tick();
    NON_SPECIFIC_EOI = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; READ_IS = 1'b0; read = 1'b1; S_P = 1'b0; AEOI = 1'b0;
    SPECIFIC_EOI = 1'b0; NON_SPECIFIC_EOI = 1'b0; V_A = 5'd0; L123 = 3'd0;
    highest_priority_int = 3'd0; SNGL = 1'b0; selected_slave = 1'b0;
    IRR_slave = 8'h00;

    // Reset state
    tick();
    expect_isr("reset", 8'h00);
    expect_bus("reset_bus", 8'h00);
    check_sb();
    rst = 1'b0;
    tick(); tick();

    // Set + AEOI, acknowledge held three clocks
    AEOI = 1'b1; V_A = 5'd0; highest_priority_int = 3'd5;
    S_P = 1'b1; tick();
    expect_isr("aeoi_set", 8'h20);
    expect_bus("aeoi_vec", 8'h05);
    check_sb();
    tick(); tick();
    expect_isr("aeoi_hold", 8'h20);
    check_sb();
    S_P = 1'b0; tick();
    expect_isr("aeoi_clear", 8'h00);
    expect_bus("aeoi_vec_keep", 8'h05);
    check_sb();

    // ISR read mux
    AEOI = 1'b0;
    ack_pulse(3'd7);
    ack_pulse(3'd2);
    expect_isr("set_84", 8'h84);
    check_sb();
    READ_IS = 1'b1; read = 1'b0; #1;
    expect_bus("rd_isr", 8'h84);
    check_sb();
    read = 1'b1; #1;
    expect_bus("rd_strobe_off", 8'h02);
    check_sb();
    READ_IS = 1'b0; read = 1'b0; #1;
    expect_bus("rd_vec_sel", 8'h02);
    check_sb();
    read = 1'b1;

    // Specific EOI
    seoi_pulse(3'd2);
    expect_isr("seoi_l2", 8'h80);
    check_sb();
    seoi_pulse(3'd7);
    expect_isr("seoi_l7", 8'h00);
    check_sb();
    seoi_pulse(3'd5);
    expect_isr("seoi_empty", 8'h00);
    check_sb();

    // Non-specific EOI
    ack_pulse(3'd3);
    ack_pulse(3'd6);
    expect_isr("set_48", 8'h48);
    check_sb();
    neoi_pulse();
    expect_isr("neoi_1", 8'h40);
    check_sb();
    neoi_pulse();
    expect_isr("neoi_2", 8'h00);
    check_sb();
    neoi_pulse();
    expect_isr("neoi_empty", 8'h00);
    check_sb();

    // Cascade
    SNGL = 1'b1; IRR_slave = 8'hFF; V_A = 5'b01000; selected_slave = 1'b0;
    ack_pulse(3'd4);
    expect_isr("casc_slave", 8'h10);
    expect_bus("casc_slave_bus", 8'h00);
    check_sb();
    selected_slave = 1'b1;
    ack_pulse(3'd4);
    expect_bus("casc_selected", 8'h44);
    check_sb();
    SNGL = 1'b0; IRR_slave = 8'h00; selected_slave = 1'b0;
    seoi_pulse(3'd4);
    expect_isr("casc_cleanup", 8'h00);
    check_sb();

    // Set and clear on the same bit: the set wins
    highest_priority_int = 3'd2; L123 = 3'd2;
    S_P = 1'b1; SPECIFIC_EOI = 1'b1; tick();
    expect_isr("collide_same", 8'h04);
    check_sb();
    S_P = 1'b0; SPECIFIC_EOI = 1'b0; tick();

    // Set and non-specific clear on different bits both apply
    highest_priority_int = 3'd1;
    S_P = 1'b1; NON_SPECIFIC_EOI = 1'b1; tick();
    expect_isr("collide_diff", 8'h02);
    check_sb();
    S_P = 1'b0; NON_SPECIFIC_EOI = 1'b0; tick();

    // AEOI clears the level latched at the rise, not the current one
    AEOI = 1'b1; highest_priority_int = 3'd6;
    S_P = 1'b1; tick();
    expect_isr("aeoi_latch_set", 8'h42);
    check_sb();
    highest_priority_int = 3'd1;
    S_P = 1'b0; tick();
    expect_isr("aeoi_latch_clr", 8'h02);
    check_sb();
    AEOI = 1'b0;

    // Asynchronous reset in the middle of an acknowledge pulse
    highest_priority_int = 3'd3;
    S_P = 1'b1; tick();
    expect_isr("pre_rst", 8'h0A);
    check_sb();
    #2 rst = 1'b1;
    #1;
    expect_isr("async_rst", 8'h00);
    expect_bus("async_rst_bus", 8'h00);
    check_sb();
    tick();
    rst = 1'b0;
    tick(); tick();
    expect_isr("no_rise_post", 8'h00);
    check_sb();
    S_P = 1'b0; tick();
    expect_isr("post_fall", 8'h00);
    check_sb();
    ack_pulse(3'd0);
    expect_isr("post_rst_set", 8'h01);
    expect_bus("post_rst_vec", 8'h40);
    check_sb();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
